// File: rtl/md_pkg.sv
// Shared constants and enums for the M-extension multiply/divide sequencer.
// Opcode/funct7 identify an M-op; funct3 selects the operation.
package md_pkg;

    localparam logic [6:0] MD_OPCODE = 7'b0110011;
    localparam logic [6:0] MD_FUNCT7 = 7'b0000001;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    function automatic logic op_is_div(input md_op_e op);
        return op[2];
    endfunction

    function automatic logic op_is_signed_div(input md_op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    // Only meaningful for divide-class ops.
    function automatic logic op_is_rem(input md_op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/md_divider.sv
// Iterative radix-2 restoring divider on unsigned magnitudes, one quotient bit per cycle.
// o_done flags the final iteration cycle; o_quotient/o_remainder then carry the finished values.
module md_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic            i_abort,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic            o_done,
    output logic [XLEN-1:0] o_quotient,
    output logic [XLEN-1:0] o_remainder
);

    localparam int CW = $clog2(XLEN + 1);

    logic [CW-1:0]   r_count;
    logic [XLEN-1:0] r_quot;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_divisor;
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_diff;
    logic            w_fits;

    // The dividend shifts out of r_quot MSB-first while quotient bits shift in at the bottom.
    assign w_shift     = {r_rem, r_quot[XLEN-1]};
    assign w_diff      = w_shift - {1'b0, r_divisor};
    assign w_fits      = ~w_diff[XLEN];
    assign o_remainder = w_fits ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
    assign o_quotient  = {r_quot[XLEN-2:0], w_fits};
    assign o_done      = (r_count == CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
        end else if (i_abort) begin
            r_count <= '0;
        end else if (i_start) begin
            r_count   <= CW'(XLEN);
            r_quot    <= i_dividend;
            r_rem     <= '0;
            r_divisor <= i_divisor;
        end else if (r_count != '0) begin
            r_count <= r_count - CW'(1);
            r_quot  <= o_quotient;
            r_rem   <= o_remainder;
        end
    end

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle M-extension execution unit: pipelined multiply, iterative divide,
// single-cycle special cases, with decode stall and flush handling.
module md_sequencer
    import md_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_d,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic            flush,
    output logic            stall_d,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [2:0]      MUL_LOAD = (MUL_CYCLES > 2) ? 3'(MUL_CYCLES - 2) : 3'd0;

    md_state_e       r_state, w_state_next;
    md_op_e          r_op;
    logic [XLEN-1:0] r_op_a, r_op_b, r_result;
    logic [2:0]      r_mul_cnt;
    logic            r_q_neg, r_r_neg;

    md_op_e          w_op;
    logic            w_mop, w_accept, w_is_div, w_signed_div;
    logic            w_a_neg, w_b_neg, w_div_zero, w_div_ovf, w_special;
    logic [XLEN-1:0] w_a_mag, w_b_mag, w_special_val;
    logic            w_div_start, w_div_done, w_load_result;
    logic [XLEN-1:0] w_div_quot, w_div_rem, w_div_final, w_result_next;
    logic [XLEN-1:0] w_mul_now, w_mul_out;

    function automatic logic [XLEN-1:0] mul_calc(input md_op_e op, input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
        logic [XLEN:0]     ea, eb;
        logic [2*XLEN+1:0] p;
        ea = {((op == OP_MULH) || (op == OP_MULHSU)) & a[XLEN-1], a};
        eb = {(op == OP_MULH) & b[XLEN-1], b};
        // Full-width sign extension makes an unsigned multiply yield the signed product bits.
        p  = {{(XLEN+1){ea[XLEN]}}, ea} * {{(XLEN+1){eb[XLEN]}}, eb};
        return (op == OP_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    assign w_op         = md_op_e'(funct3);
    assign w_mop        = (opcode == MD_OPCODE) && (funct7 == MD_FUNCT7);
    assign w_accept     = valid_d && w_mop && (r_state == ST_IDLE) && !flush;
    assign w_is_div     = op_is_div(w_op);
    assign w_signed_div = op_is_signed_div(w_op);
    assign w_a_neg      = w_signed_div & rs1_val[XLEN-1];
    assign w_b_neg      = w_signed_div & rs2_val[XLEN-1];
    assign w_a_mag      = w_a_neg ? -rs1_val : rs1_val;
    assign w_b_mag      = w_b_neg ? -rs2_val : rs2_val;
    assign w_div_zero   = (rs2_val == '0);
    assign w_div_ovf    = w_signed_div && (rs1_val == MOST_NEG) && (rs2_val == '1);
    assign w_special    = w_is_div && (w_div_zero || w_div_ovf);

    always_comb begin
        w_special_val = rs1_val;
        if (w_div_zero)
            w_special_val = op_is_rem(w_op) ? rs1_val : '1;
        else if (w_div_ovf)
            w_special_val = op_is_rem(w_op) ? '0 : rs1_val;
    end

    md_divider #(.XLEN(XLEN)) u_divider (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_div_start),
        .i_abort     (flush),
        .i_dividend  (w_a_mag),
        .i_divisor   (w_b_mag),
        .o_done      (w_div_done),
        .o_quotient  (w_div_quot),
        .o_remainder (w_div_rem)
    );

    // Quotient negates when operand signs differ; remainder follows the dividend.
    assign w_div_final = op_is_rem(r_op) ? (r_r_neg ? -w_div_rem : w_div_rem)
                                         : (r_q_neg ? -w_div_quot : w_div_quot);

    assign w_mul_now = mul_calc(r_op, r_op_a, r_op_b);

    generate
        if (MUL_CYCLES <= 2) begin : g_mul_comb
            assign w_mul_out = w_mul_now;
        end else begin : g_mul_pipe
            logic [XLEN-1:0] r_pipe [MUL_CYCLES-2];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < MUL_CYCLES - 2; i++) r_pipe[i] <= '0;
                end else begin
                    r_pipe[0] <= w_mul_now;
                    for (int i = 1; i < MUL_CYCLES - 2; i++) r_pipe[i] <= r_pipe[i-1];
                end
            end
            assign w_mul_out = r_pipe[MUL_CYCLES-3];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next  = r_state;
        w_div_start   = 1'b0;
        w_load_result = 1'b0;
        w_result_next = r_result;
        busy          = (r_state != ST_IDLE);
        result_valid  = (r_state == ST_DONE) && !flush && !rst;
        stall_d       = valid_d && w_mop && (r_state != ST_DONE) && !flush && !rst;
        if (flush) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_special) begin
                            w_state_next  = ST_DONE;
                            w_load_result = 1'b1;
                            w_result_next = w_special_val;
                        end else if (w_is_div) begin
                            w_state_next = ST_DIV;
                            w_div_start  = 1'b1;
                        end else if (MUL_CYCLES == 1) begin
                            w_state_next  = ST_DONE;
                            w_load_result = 1'b1;
                            w_result_next = mul_calc(w_op, rs1_val, rs2_val);
                        end else begin
                            w_state_next = ST_MUL;
                        end
                    end
                end
                ST_MUL: begin
                    if (r_mul_cnt == 3'd0) begin
                        w_state_next  = ST_DONE;
                        w_load_result = 1'b1;
                        w_result_next = w_mul_out;
                    end
                end
                ST_DIV: begin
                    if (w_div_done) begin
                        w_state_next  = ST_DONE;
                        w_load_result = 1'b1;
                        w_result_next = w_div_final;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= OP_MUL;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_q_neg   <= 1'b0;
            r_r_neg   <= 1'b0;
            r_mul_cnt <= 3'd0;
            r_result  <= '0;
        end else begin
            if (w_accept) begin
                r_op      <= w_op;
                r_op_a    <= rs1_val;
                r_op_b    <= rs2_val;
                r_q_neg   <= w_a_neg ^ w_b_neg;
                r_r_neg   <= w_a_neg;
                r_mul_cnt <= MUL_LOAD;
            end else if ((r_state == ST_MUL) && (r_mul_cnt != 3'd0)) begin
                r_mul_cnt <= r_mul_cnt - 3'd1;
            end
            if (w_load_result) r_result <= w_result_next;
        end
    end

    assign result = r_result;

endmodule

// File: doc/md_sequencer.md
MD_SEQUENCER -- requirements
Module: md_sequencer

Interface
REQ-001 Parameter XLEN, default 32, datapath width.
REQ-002 Parameter MUL_CYCLES, default 2, multiply latency in cycles; legal range 1..8.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 valid_d  input  1  decode-stage instruction valid.
REQ-006 opcode  input  7  instruction opcode field.
REQ-007 funct3  input  3  operation select.
REQ-008 funct7  input  7  extension select.
REQ-009 rs1_val  input  XLEN  operand A.
REQ-010 rs2_val  input  XLEN  operand B.
REQ-011 flush  input  1  kill in-flight operation.
REQ-012 stall_d  output  1  hold fetch/decode.
REQ-013 busy  output  1  state not IDLE.
REQ-014 result_valid  output  1  single-cycle result strobe.
REQ-015 result  output  XLEN  operation result.

Function
REQ-016 M-op decode: opcode==7'b0110011 and funct7==7'b0000001; funct3 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-017 Accept: valid_d && M-op && state==IDLE && !flush; operands and funct3 captured on that edge (cycle T).
REQ-018 States: IDLE, MUL, DIV, DONE.
REQ-019 IDLE->MUL on accepted multiply; IDLE->DIV on accepted divide/remainder; IDLE->DONE directly for divide-by-zero or signed overflow.
REQ-020 MUL->DONE after MUL_CYCLES-1 cycles in MUL; result_valid at T+MUL_CYCLES.
REQ-021 DIV: radix-2 restoring iteration, one quotient bit per cycle, XLEN cycles; result_valid at T+XLEN+1.
REQ-022 DONE: result_valid=1 for exactly one cycle, then DONE->IDLE.
REQ-023 Multiply: full 2*XLEN product; MUL low half; MULH signed x signed high half; MULHSU signed rs1 x unsigned rs2 high half; MULHU unsigned high half.
REQ-024 Divide by zero: DIV/DIVU all-ones, REM/REMU rs1_val; result_valid at T+1.
REQ-025 Signed overflow (rs1=most-negative, rs2=-1): DIV rs1_val, REM 0; result_valid at T+1.
REQ-026 Signed divide: operate on magnitudes; quotient negated when signs differ; remainder takes dividend sign.
REQ-027 stall_d = valid_d && M-op && !(state==DONE) && !flush, combinational.
REQ-028 result holds last value while result_valid low; only sampled when result_valid=1.
REQ-029 flush in any state: next state IDLE, no result_valid that cycle or later for the killed op; flush coincident with DONE suppresses result_valid.
REQ-030 Non-M-op or valid_d low in IDLE: no state change, stall_d low.
REQ-031 New accept not possible in DONE; a back-to-back M-op is accepted in the IDLE cycle after DONE.

Reset
REQ-032 rst: state=IDLE, stall_d=0, busy=0, result_valid=0, result=0, iteration counter=0, operand registers=0.
REQ-033 rst overrides flush and accept in the same cycle; in-flight op abandoned with no result_valid.

Structure
REQ-034 Package md_pkg holds: M-op opcode/funct7 constants, funct3 op enum, state enum.
REQ-035 One sub-module md_divider (iterative restoring core, start/done handshake, XLEN-parametrised); multiply pipeline stays in md_sequencer.

Verification
REQ-036 MUL 7 x -3 at T, MUL_CYCLES=2 -> result_valid at T+2, result 0xFFFFFFEB; stall_d high T..T+1, low T+2.
REQ-037 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> result 0xFFFFFFFF.
REQ-038 DIV -7 / 2 -> quotient 0xFFFFFFFD at T+33; REM -7 % 2 -> 0xFFFFFFFF.
REQ-039 DIVU 5/0 -> 0xFFFFFFFF at T+1; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at T+1; REM same operands -> 0.
REQ-040 flush at T+10 of a DIV -> busy low T+11, no result_valid through T+40; next DIV accepted and correct.
REQ-041 rst asserted mid-DIV at T+5 -> all outputs at reset values T+6; flush and rst coincident with DONE -> no strobe.
